// File: rtl/lut_sweep_pkg.sv
// lut_sweep shared types: FSM state encoding, table sizing helper
// and the default 3-input truth table x & ~(y & z).
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] TT_INIT_3 = 8'h70;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lut_sweep_lookup.sv
// tt_lookup: 2^N:1 mux selecting one truth-table bit by input vector.
// Ports: tt (table), vec (select), bit_o (tt[vec]).
module tt_lookup
  import lut_sweep_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [tt_width(N)-1:0] tt,
  input  logic [N-1:0]           vec,
  output logic                   bit_o
);

  assign bit_o = tt[vec];

endmodule

// File: rtl/lut_sweep.sv
// lut_sweep: registered N-input truth-table evaluator plus a handshaked
// sweep engine reporting every vector and counting minterms.
// Ports: clk/rst, tt_load/tt_data, eval_x/eval_s, start/busy,
// out_valid/out_ready/out_vec/out_s/out_last, done, ones_cnt.
module lut_sweep
  import lut_sweep_pkg::*;
#(
  parameter int                         N_IN    = 3,
  parameter logic [tt_width(N_IN)-1:0] TT_INIT = TT_INIT_3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tt_load,
  input  logic [tt_width(N_IN)-1:0] tt_data,
  input  logic [N_IN-1:0]           eval_x,
  output logic                      eval_s,
  input  logic                      start,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_IN-1:0]           out_vec,
  output logic                      out_s,
  output logic                      out_last,
  output logic                      done,
  output logic [N_IN:0]             ones_cnt
);

  localparam int TW = tt_width(N_IN);
  localparam logic [N_IN-1:0] VMAX = '1;

  state_e            st_q, st_d;
  logic [TW-1:0]     tt_q, tt_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              eval_s_q, eval_s_d;
  logic              live_bit;
  logic              sweep_bit;

  tt_lookup #(.N(N_IN)) u_live (
    .tt    (tt_q),
    .vec   (eval_x),
    .bit_o (live_bit)
  );

  tt_lookup #(.N(N_IN)) u_sweep (
    .tt    (tt_q),
    .vec   (vec_q),
    .bit_o (sweep_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      tt_q     <= TT_INIT;
      vec_q    <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      eval_s_q <= TT_INIT[0];
    end else begin
      st_q     <= st_d;
      tt_q     <= tt_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      eval_s_q <= eval_s_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    tt_d     = tt_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    eval_s_d = live_bit;
    unique case (st_q)
      IDLE: begin
        // Table write and start may coincide; the sweep
        // then reads the freshly written table.
        if (tt_load) tt_d = tt_data;
        if (start) begin
          st_d  = SWEEP;
          vec_d = '0;
          cnt_d = '0;
          vld_d = 1'b1;
        end
      end
      SWEEP: begin
        if (vld_q && out_ready) begin
          cnt_d = cnt_q + {{N_IN{1'b0}}, sweep_bit};
          if (vec_q == VMAX) begin
            vld_d = 1'b0;
            st_d  = DONE;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  assign eval_s    = eval_s_q;
  assign busy      = (st_q != IDLE);
  assign out_valid = vld_q;
  assign out_vec   = vec_q;
  assign out_s     = sweep_bit;
  // vec_q parks at the top vector after a sweep, so qualify
  // last with valid to keep it a per-beat flag.
  assign out_last  = vld_q && (vec_q == VMAX);
  assign done      = (st_q == DONE);
  assign ones_cnt  = cnt_q;

endmodule

// File: tb/tb_lut_sweep.sv
// Self-checking bench for lut_sweep (N_IN = 3) against a table-level
// reference model: f(v) = table bit v, minterm count = popcount(table).
module tb_lut_sweep;

  localparam int N = 3;
  localparam int TW = 8;
  localparam logic [7:0] TT_DEF = 8'h70;

  logic          clk;
  logic          rst;
  logic          tt_load;
  logic [TW-1:0] tt_data;
  logic [N-1:0]  eval_x;
  logic          eval_s;
  logic          start;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_vec;
  logic          out_s;
  logic          out_last;
  logic          done;
  logic [N:0]    ones_cnt;

  int n_cmp;
  int n_err;
  logic [7:0] model;

  lut_sweep #(.N_IN(N), .TT_INIT(TT_DEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .tt_load   (tt_load),
    .tt_data   (tt_data),
    .eval_x    (eval_x),
    .eval_s    (eval_s),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_s     (out_s),
    .out_last  (out_last),
    .done      (done),
    .ones_cnt  (ones_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_idle_reset(input string nm);
    n_cmp++;
    if ({eval_s, busy, out_valid, out_vec, out_s, out_last, done, ones_cnt}
        !== {model[0], 1'b0, 1'b0, 3'd0, model[0], 1'b0, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL %s: got es=%b busy=%b v=%b vec=%0d s=%b last=%b done=%b cnt=%0d want es=%b s=%b rest 0",
               nm, eval_s, busy, out_valid, out_vec, out_s, out_last, done,
               ones_cnt, model[0], model[0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tt_load = 1'b0;
    tt_data = '0;
    eval_x = '0;
    start = 1'b0;
    out_ready = 1'b0;
    model = TT_DEF;
    repeat (2) @(negedge clk);
    check_idle_reset("reset_held");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_reset("reset_released");
  endtask

  task automatic test_live(input int n);
    for (int i = 0; i < n; i++) begin
      logic [N-1:0] x;
      if (i == 0) x = 3'b101;
      else if (i == 1) x = 3'b111;
      else x = N'($urandom);
      eval_x = x;
      @(negedge clk);
      n_cmp++;
      if (eval_s !== model[x]) begin
        n_err++;
        $display("FAIL live x=%0d: got %b want %b", x, eval_s, model[x]);
      end
    end
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  // noise: pulse start/tt_load with random data while busy.
  task automatic run_sweep(input bit do_load, input logic [7:0] tbl_new,
                           input int ready_mode, input bit noise);
    int k;
    int cyc;
    int stalls;
    int step;
    bit rdy;
    int exp_cnt;
    if (do_load) begin
      tt_load = 1'b1;
      tt_data = tbl_new;
      model = tbl_new;
    end
    start = 1'b1;
    out_ready = 1'b1;
    exp_cnt = $countones(model);
    @(negedge clk);
    start = 1'b0;
    tt_load = 1'b0;
    k = 0;
    cyc = 1;
    stalls = 0;
    step = 0;
    while (k < TW && cyc < 200) begin
      n_cmp++;
      if ({out_valid, busy, done, out_vec, out_s, out_last}
          !== {1'b1, 1'b1, 1'b0, 3'(k), model[k], (k == TW - 1)}) begin
        n_err++;
        $display("FAIL sweep_beat k=%0d: got v=%b busy=%b done=%b vec=%0d s=%b last=%b want s=%b last=%b",
                 k, out_valid, busy, done, out_vec, out_s, out_last,
                 model[k], (k == TW - 1));
      end
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = (step % 3 == 0);
        default: rdy = 1'($urandom);
      endcase
      step++;
      out_ready = rdy;
      if (noise) begin
        start = 1'($urandom);
        tt_load = 1'($urandom);
        tt_data = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (rdy) k++;
      else stalls++;
    end
    n_cmp++;
    if (k < TW) begin
      n_err++;
      $display("FAIL sweep_timeout: reached k=%0d want %0d", k, TW);
    end else if ({done, busy, out_valid, ones_cnt} !== {1'b1, 1'b1, 1'b0, 4'(exp_cnt)}
                 || cyc != TW + 1 + stalls) begin
      n_err++;
      $display("FAIL sweep_done: got done=%b busy=%b v=%b cnt=%0d cyc=%0d want 1 1 0 cnt=%0d cyc=%0d",
               done, busy, out_valid, ones_cnt, cyc, exp_cnt, TW + 1 + stalls);
    end
    @(negedge clk);
    start = 1'b0;
    tt_load = 1'b0;
    n_cmp++;
    if ({done, busy, out_valid, out_last, ones_cnt}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 4'(exp_cnt)}) begin
      n_err++;
      $display("FAIL sweep_idle: got done=%b busy=%b v=%b last=%b cnt=%0d want 0 0 0 0 cnt=%0d",
               done, busy, out_valid, out_last, ones_cnt, exp_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, ones_cnt} !== {1'b0, 4'(exp_cnt)}) begin
      n_err++;
      $display("FAIL no_queued_start: got busy=%b cnt=%0d want 0 %0d",
               busy, ones_cnt, exp_cnt);
    end
  endtask

  task automatic test_sweep_default();
    run_sweep(1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_load_ff();
    tt_load = 1'b1;
    tt_data = 8'hFF;
    model = 8'hFF;
    @(negedge clk);
    tt_load = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL load_no_start: got busy=%b want 0", busy);
    end
    run_sweep(1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_sweep(1'b1, 8'hA6, 1, 1'b0);
    run_sweep(1'b0, 8'h00, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t;
    run_sweep(1'b1, 8'h5C, 0, 1'b0);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (out_vec !== 3'd4 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (out_vec !== 3'd4) begin
      n_err++;
      $display("FAIL mid_reach: got vec=%0d want 4", out_vec);
    end
    rst = 1'b1;
    model = TT_DEF;
    #1;
    check_idle_reset("mid_reset_async");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({done, busy, out_valid} !== 3'b000) begin
        n_err++;
        $display("FAIL mid_no_done c=%0d: got done=%b busy=%b v=%b want 000",
                 i, done, busy, out_valid);
      end
    end
    run_sweep(1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_same_cycle();
    run_sweep(1'b1, 8'h01, 0, 1'b1);
    test_live(4);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      run_sweep(1'b1, 8'($urandom), 2, 1'b1);
      test_live(5);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_live(6);
    test_sweep_default();
    test_load_ff();
    test_backpressure();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
